// File: rtl/pll_clk_seq.sv
// pll_clk_seq: PLL lock qualifier, staggered channel reset release and
// per-channel programmable clock-enable strobes, all in the CLK domain.
//
// Ports:
//   CLK, RST_N    fast clock, synchronous active-low reset
//   locked        asynchronous PLL LOCK input
//   div_cfg       channel i divide ratio at [i*DIV_W +: DIV_W]
//   lost_clr      clears the sticky lock_lost flag
//   ch_rst_n      per-channel active-low reset (released ch0 first)
//   ch_ce         per-channel one-cycle clock-enable strobe (registered)
//   ready         all channels released
//   lock_lost     sticky: lock dropped after leaving WAIT_LOCK
//   lock_loss_cnt saturating count of loss events (PLL_LOSS_CNT_EN only)
//
// Build option: define PLL_LOSS_CNT_EN to add the lock_loss_cnt output.

module pll_clk_seq #(
    parameter int NCH         = 4,
    parameter int DIV_W       = 8,
    parameter int STABLE_CYC  = 1024,
    parameter int STAGGER_CYC = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 locked,
    input  logic [NCH*DIV_W-1:0] div_cfg,
    input  logic                 lost_clr,
    output logic [NCH-1:0]       ch_rst_n,
    output logic [NCH-1:0]       ch_ce,
    output logic                 ready,
    output logic                 lock_lost
`ifdef PLL_LOSS_CNT_EN
    ,
    output logic [15:0]          lock_loss_cnt
`endif
);

    localparam int SW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam int GW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [GW-1:0] STG_LAST  = GW'(STAGGER_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic          sync_q, lk;
    logic [SW-1:0] stab_cnt, stab_nxt;
    logic [GW-1:0] stg_cnt, stg_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          lose;

    logic [NCH-1:0][DIV_W-1:0] div_cnt;
    logic [NCH-1:0][DIV_W-1:0] div_q;
    logic [NCH-1:0][DIV_W-1:0] d_eff;

    // Two-flop synchroniser for the asynchronous LOCK.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q <= 1'b0;
            lk     <= 1'b0;
        end else begin
            sync_q <= locked;
            lk     <= sync_q;
        end
    end

    // State register, including the sequencing counters.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            stg_cnt  <= '0;
            idx      <= '0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            stg_cnt  <= stg_nxt;
            idx      <= idx_nxt;
        end
    end

    // Next-state logic. Any lock drop outside WAIT_LOCK is a loss event.
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        stg_nxt   = stg_cnt;
        idx_nxt   = idx;
        lose      = 1'b0;
        unique case (state)
            WAIT_LOCK: begin
                stab_nxt = '0;
                stg_nxt  = '0;
                idx_nxt  = '0;
                if (lk) begin
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (!lk) begin
                    lose = 1'b1;
                end else if (stab_cnt == STAB_LAST) begin
                    state_nxt = RELEASE;
                    idx_nxt   = '0;
                    stg_nxt   = '0;
                end else begin
                    stab_nxt = stab_cnt + SW'(1);
                end
            end
            RELEASE: begin
                if (!lk) begin
                    lose = 1'b1;
                end else if (idx == IDX_LAST) begin
                    // Last channel was released last cycle.
                    state_nxt = RUN;
                end else if (stg_cnt == STG_LAST) begin
                    idx_nxt = idx + IW'(1);
                    stg_nxt = '0;
                end else begin
                    stg_nxt = stg_cnt + GW'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    lose = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
        if (lose) begin
            state_nxt = WAIT_LOCK;
            stab_nxt  = '0;
            stg_nxt   = '0;
            idx_nxt   = '0;
        end
    end

    // Outputs decoded from registered state only: release is cumulative,
    // channels 0..idx are out of reset while in RELEASE.
    always_comb begin
        ch_rst_n = '0;
        ready    = (state == RUN);
        for (int i = 0; i < NCH; i++) begin
            ch_rst_n[i] = (state == RUN) ||
                          ((state == RELEASE) && (IW'(i) <= idx));
        end
    end

    // Sticky loss flag; a loss in the same cycle beats lost_clr.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lock_lost <= 1'b0;
        end else if (lose) begin
            lock_lost <= 1'b1;
        end else if (lost_clr) begin
            lock_lost <= 1'b0;
        end
    end

`ifdef PLL_LOSS_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lock_loss_cnt <= '0;
        end else if (lose && (lock_loss_cnt != 16'hFFFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end
    end
`endif

    // The divide field is only picked up at a period start (counter at 0);
    // mid-period the stored copy keeps the running period intact.
    always_comb begin
        d_eff = '0;
        for (int i = 0; i < NCH; i++) begin
            d_eff[i] = (div_cnt[i] == '0) ? div_cfg[i*DIV_W +: DIV_W]
                                          : div_q[i];
        end
    end

    // Divider counters. They are cleared both while the channel is held
    // in reset and on the loss edge itself, so ch_ce drops together with
    // ch_rst_n.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            div_cnt <= '0;
            div_q   <= '0;
            ch_ce   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!ch_rst_n[i] || lose) begin
                    div_cnt[i] <= '0;
                    div_q[i]   <= '0;
                    ch_ce[i]   <= 1'b0;
                end else begin
                    if (div_cnt[i] == '0) begin
                        div_q[i] <= d_eff[i];
                    end
                    if (d_eff[i] <= DIV_W'(1)) begin
                        div_cnt[i] <= '0;
                        ch_ce[i]   <= 1'b1;
                    end else if (div_cnt[i] == d_eff[i] - DIV_W'(1)) begin
                        div_cnt[i] <= '0;
                        ch_ce[i]   <= 1'b1;
                    end else begin
                        div_cnt[i] <= div_cnt[i] + DIV_W'(1);
                        ch_ce[i]   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_clk_seq.sv
// tb_pll_clk_seq: directed bench for pll_clk_seq (NCH=4, STABLE_CYC=8,
// STAGGER_CYC=4) with hand-computed expected values.

module tb_pll_clk_seq;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        locked;
    logic [31:0] div_cfg;
    logic        lost_clr;
    logic [3:0]  ch_rst_n;
    logic [3:0]  ch_ce;
    logic        ready;
    logic        lock_lost;
`ifdef PLL_LOSS_CNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int ecount = 0;

    pll_clk_seq #(
        .NCH(4),
        .DIV_W(8),
        .STABLE_CYC(8),
        .STAGGER_CYC(4)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .locked(locked),
        .div_cfg(div_cfg),
        .lost_clr(lost_clr),
        .ch_rst_n(ch_rst_n),
        .ch_ce(ch_ce),
        .ready(ready),
        .lock_lost(lock_lost)
`ifdef PLL_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, ecount);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            ecount++;
        end
    endtask

    task automatic go_to(input int e);
        while (ecount < e) step(1);
    endtask

    initial begin
        RST_N    = 1'b0;
        locked   = 1'b0;
        lost_clr = 1'b0;
        div_cfg  = {8'd255, 8'd3, 8'd1, 8'd0};
        step(2);
        check("rst_ch_rst_n", 32'(ch_rst_n), 32'h0);
        check("rst_ch_ce", 32'(ch_ce), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_lock_lost", 32'(lock_lost), 32'h0);
        RST_N = 1'b1;
        step(3);
        check("idle_no_release", 32'(ch_rst_n), 32'h0);

        // Lock glitch while stab_cnt==5.
        locked = 1'b1;
        ecount = -1;
        go_to(5);
        locked = 1'b0;
        go_to(6);
        locked = 1'b1;
        go_to(8);
        check("glitch_lost", 32'(lock_lost), 32'h1);
        check("glitch_no_rel", 32'(ch_rst_n), 32'h0);
`ifdef PLL_LOSS_CNT_EN
        check("glitch_cnt", 32'(lock_loss_cnt), 32'h1);
`endif
        go_to(16);
        check("glitch_restart", 32'(ch_rst_n), 32'h0);
        go_to(17);
        check("glitch_rel_ch0", 32'(ch_rst_n), 32'h1);

        // Mid-operation reset.
        RST_N  = 1'b0;
        locked = 1'b0;
        step(1);
        check("mid_rst_ch_rst_n", 32'(ch_rst_n), 32'h0);
        check("mid_rst_ce", 32'(ch_ce), 32'h0);
        check("mid_rst_lost", 32'(lock_lost), 32'h0);
        check("mid_rst_ready", 32'(ready), 32'h0);
`ifdef PLL_LOSS_CNT_EN
        check("mid_rst_cnt", 32'(lock_loss_cnt), 32'h0);
`endif
        RST_N = 1'b1;

        // Full sequence: locked at E0, STABLE at E2, ch0 at E10.
        locked = 1'b1;
        ecount = -1;
        go_to(9);
        check("seq_pre_rel", 32'(ch_rst_n), 32'h0);
        go_to(10);
        check("seq_ch0", 32'(ch_rst_n), 32'h1);
        check("seq_ce_e10", 32'(ch_ce), 32'h0);
        go_to(11);
        check("seq_ce_ch0", 32'(ch_ce), 32'h1);
        go_to(13);
        check("seq_ch0_hold", 32'(ch_rst_n), 32'h1);
        go_to(14);
        check("seq_ch1", 32'(ch_rst_n), 32'h3);
        go_to(15);
        check("seq_ce_ch1", 32'(ch_ce), 32'h3);
        go_to(18);
        check("seq_ch2", 32'(ch_rst_n), 32'h7);
        go_to(20);
        check("ce2_wait", 32'(ch_ce), 32'h3);
        go_to(21);
        check("ce2_first", 32'(ch_ce), 32'h7);
        go_to(22);
        check("seq_ch3", 32'(ch_rst_n), 32'hF);
        check("seq_not_ready", 32'(ready), 32'h0);
        go_to(23);
        check("seq_ready", 32'(ready), 32'h1);
        go_to(24);
        check("ce2_second", 32'(ch_ce), 32'h7);
        go_to(276);
        check("ce3_before", 32'(ch_ce), 32'h7);
        go_to(277);
        check("ce3_first", 32'(ch_ce), 32'hB);

        // Divide change 3->5 mid-period.
        go_to(280);
        div_cfg[23:16] = 8'd5;
        go_to(281);
        check("div_chg_281", 32'(ch_ce), 32'h3);
        go_to(282);
        check("div_chg_old_end", 32'(ch_ce), 32'h7);
        go_to(285);
        check("div_chg_285", 32'(ch_ce), 32'h3);
        go_to(286);
        check("div_chg_286", 32'(ch_ce), 32'h3);
        go_to(287);
        check("div_chg_new", 32'(ch_ce), 32'h7);

        // Lock drop in RUN.
        locked = 1'b0;
        step(2);
        check("drop_still_run", 32'(ready), 32'h1);
        check("drop_still_rel", 32'(ch_rst_n), 32'hF);
        step(1);
        check("drop_ch_rst_n", 32'(ch_rst_n), 32'h0);
        check("drop_ce", 32'(ch_ce), 32'h0);
        check("drop_ready", 32'(ready), 32'h0);
        check("drop_lost", 32'(lock_lost), 32'h1);
        lost_clr = 1'b1;
        step(1);
        lost_clr = 1'b0;
        check("lost_clr", 32'(lock_lost), 32'h0);
        step(2);
        check("lost_stays_clr", 32'(lock_lost), 32'h0);

        // Re-lock repeats the sequence.
        locked = 1'b1;
        ecount = -1;
        go_to(9);
        check("relock_pre", 32'(ch_rst_n), 32'h0);
        go_to(10);
        check("relock_ch0", 32'(ch_rst_n), 32'h1);
        go_to(23);
        check("relock_ready", 32'(ready), 32'h1);
        check("relock_all", 32'(ch_rst_n), 32'hF);

        // Set wins over lost_clr on the loss edge.
        locked = 1'b0;
        step(2);
        lost_clr = 1'b1;
        step(1);
        lost_clr = 1'b0;
        check("set_wins", 32'(lock_lost), 32'h1);

        // Three loss events from a clean reset.
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        for (int n = 0; n < 3; n++) begin
            locked = 1'b1;
            step(4);
            locked = 1'b0;
            step(3);
        end
        check("loss3_lost", 32'(lock_lost), 32'h1);
`ifdef PLL_LOSS_CNT_EN
        check("loss3_cnt", 32'(lock_loss_cnt), 32'h3);
`endif
        lost_clr = 1'b1;
        step(1);
        lost_clr = 1'b0;
        check("loss3_clr", 32'(lock_lost), 32'h0);
`ifdef PLL_LOSS_CNT_EN
        check("loss3_cnt_kept", 32'(lock_loss_cnt), 32'h3);
`endif
        RST_N = 1'b0;
        step(1);
        check("final_rst_rel", 32'(ch_rst_n), 32'h0);
        check("final_rst_ready", 32'(ready), 32'h0);
`ifdef PLL_LOSS_CNT_EN
        check("final_rst_cnt", 32'(lock_loss_cnt), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
